// File: rtl/dmem_responder_if.sv
//==============================================================================
// Module   : dmem_responder_if
// Desc     : Core MEM-stage data port plus console sink valid/ready handshake.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  addr_allign;
    logic        B;
    logic        H;
    logic [31:0] rdata;
    logic        timer_irq;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        acc_err;

    modport master (
        output mem_read, mem_write, addr, wdata, addr_allign, B, H, tx_ready,
        input  rdata, timer_irq, tx_valid, tx_data, acc_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata, addr_allign, B, H, tx_ready,
        output rdata, timer_irq, tx_valid, tx_data, acc_err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
//==============================================================================
// Module   : dmem_responder
// Desc     : Data RAM with byte lanes, 64-bit machine timer and console FIFO.
// Revision : 1.0
//==============================================================================
`default_nettype none

module dmem_responder #(
    parameter int RAM_AW  = 12,
    parameter int FIFO_AW = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dmem_responder_if.slave   bus
);
    localparam int             c_cw             = FIFO_AW + 1;
    localparam logic [c_cw-1:0] c_depth         = c_cw'(2 ** FIFO_AW);
    localparam logic [2:0]     c_reg_mtime_lo   = 3'd0;
    localparam logic [2:0]     c_reg_mtime_hi   = 3'd1;
    localparam logic [2:0]     c_reg_cmp_lo     = 3'd2;
    localparam logic [2:0]     c_reg_cmp_hi     = 3'd3;
    localparam logic [2:0]     c_reg_tx         = 3'd4;
    localparam logic [2:0]     c_reg_status     = 3'd5;

    logic [31:0]        r_mem [2**RAM_AW];
    logic [7:0]         r_fifo [2**FIFO_AW];

    logic [63:0]        r_mtime_q, w_mtime_d;
    logic [63:0]        r_mtimecmp_q, w_mtimecmp_d;
    logic               r_irq_q, w_irq_d;
    logic [FIFO_AW-1:0] r_wptr_q, w_wptr_d;
    logic [FIFO_AW-1:0] r_rptr_q, w_rptr_d;
    logic [c_cw-1:0]    r_count_q, w_count_d;
    logic               r_ovf_q, w_ovf_d;
    logic               r_acc_err_q, w_acc_err_d;

    logic               w_is_mmio, w_is_byte, w_is_half, w_is_word, w_aligned;
    logic [2:0]         w_reg;
    logic [RAM_AW-1:0]  w_ram_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_lane_data;
    logic               w_ram_we, w_cmp_lo_we, w_cmp_hi_we, w_push;
    logic               w_full, w_empty, w_push_ok, w_pop;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata;
    logic               w_unused_addr;

    assign w_unused_addr = ^{bus.addr[30:RAM_AW+2], bus.addr[1:0]};

    // B takes priority over H when both are set.
    assign w_is_mmio = bus.addr[31];
    assign w_is_byte = bus.B;
    assign w_is_half = bus.H & ~bus.B;
    assign w_is_word = ~bus.B & ~bus.H;
    assign w_aligned = w_is_byte
                     | (w_is_half & ~bus.addr_allign[0])
                     | (w_is_word & (bus.addr_allign == 2'b00));
    assign w_reg     = bus.addr[4:2];
    assign w_ram_idx = bus.addr[RAM_AW+1:2];

    always_comb begin
        w_be        = 4'b1111;
        w_lane_data = bus.wdata;
        if (w_is_byte) begin
            w_be        = 4'b0001 << bus.addr_allign;
            w_lane_data = {4{bus.wdata[7:0]}};
        end else if (w_is_half) begin
            w_be        = bus.addr_allign[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{bus.wdata[15:0]}};
        end
    end

    always_comb begin
        w_ram_we    = 1'b0;
        w_cmp_lo_we = 1'b0;
        w_cmp_hi_we = 1'b0;
        w_push      = 1'b0;
        w_acc_err_d = 1'b0;
        if (bus.mem_write) begin
            if (!w_is_mmio) begin
                w_ram_we    = w_aligned;
                w_acc_err_d = ~w_aligned;
            end else begin
                case (w_reg)
                    c_reg_cmp_lo: begin
                        w_cmp_lo_we = w_is_word & w_aligned;
                        w_acc_err_d = ~(w_is_word & w_aligned);
                    end
                    c_reg_cmp_hi: begin
                        w_cmp_hi_we = w_is_word & w_aligned;
                        w_acc_err_d = ~(w_is_word & w_aligned);
                    end
                    c_reg_tx: w_push = 1'b1;
                    default:  w_push = 1'b0;
                endcase
            end
        end
    end

    // Full is judged before the pop, so a push on a full FIFO is dropped even when a pop frees a slot.
    assign w_full    = (r_count_q == c_depth);
    assign w_empty   = (r_count_q == '0);
    assign w_push_ok = w_push & ~w_full;
    assign w_pop     = ~w_empty & bus.tx_ready;

    always_comb begin
        w_mtime_d    = r_mtime_q + 64'd1;
        w_mtimecmp_d = {w_cmp_hi_we ? bus.wdata : r_mtimecmp_q[63:32],
                        w_cmp_lo_we ? bus.wdata : r_mtimecmp_q[31:0]};
        w_irq_d      = (r_mtime_q >= r_mtimecmp_q);
        w_wptr_d     = r_wptr_q + FIFO_AW'(w_push_ok);
        w_rptr_d     = r_rptr_q + FIFO_AW'(w_pop);
        w_count_d    = r_count_q + c_cw'(w_push_ok) - c_cw'(w_pop);
        w_ovf_d      = r_ovf_q | (w_push & w_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime_q    <= 64'd0;
            r_mtimecmp_q <= '1;
            r_irq_q      <= 1'b0;
            r_wptr_q     <= '0;
            r_rptr_q     <= '0;
            r_count_q    <= '0;
            r_ovf_q      <= 1'b0;
            r_acc_err_q  <= 1'b0;
        end else begin
            r_mtime_q    <= w_mtime_d;
            r_mtimecmp_q <= w_mtimecmp_d;
            r_irq_q      <= w_irq_d;
            r_wptr_q     <= w_wptr_d;
            r_rptr_q     <= w_rptr_d;
            r_count_q    <= w_count_d;
            r_ovf_q      <= w_ovf_d;
            r_acc_err_q  <= w_acc_err_d;
        end
    end

    // Storage arrays keep their contents through reset; writes are suppressed while it is held.
    always_ff @(posedge clk) begin
        if (!rst && w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_ram_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
            end
        end
        if (!rst && w_push_ok) r_fifo[r_wptr_q] <= bus.wdata[7:0];
    end

    assign w_status = 32'({r_count_q, 5'b00000, r_ovf_q, w_empty, w_full});

    always_comb begin
        w_rdata = 32'h0;
        if (bus.mem_read) begin
            if (!w_is_mmio) begin
                w_rdata = r_mem[w_ram_idx];
            end else begin
                case (w_reg)
                    c_reg_mtime_lo: w_rdata = r_mtime_q[31:0];
                    c_reg_mtime_hi: w_rdata = r_mtime_q[63:32];
                    c_reg_cmp_lo:   w_rdata = r_mtimecmp_q[31:0];
                    c_reg_cmp_hi:   w_rdata = r_mtimecmp_q[63:32];
                    c_reg_status:   w_rdata = w_status;
                    default:        w_rdata = 32'h0;
                endcase
            end
        end
    end

    assign bus.rdata     = w_rdata;
    assign bus.timer_irq = r_irq_q;
    assign bus.tx_valid  = ~w_empty;
    assign bus.tx_data   = w_empty ? 8'h00 : r_fifo[r_rptr_q];
    assign bus.acc_err   = r_acc_err_q;
endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// Module   : tb_dmem_responder
// Desc     : Self-checking bench for dmem_responder against a byte/queue model.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;
    localparam logic [31:0] c_mtime_lo = 32'h8000_0000;
    localparam logic [31:0] c_cmp_lo   = 32'h8000_0008;
    localparam logic [31:0] c_cmp_hi   = 32'h8000_000C;
    localparam logic [31:0] c_tx       = 32'h8000_0010;
    localparam logic [31:0] c_status   = 32'h8000_0014;
    localparam logic [31:0] c_reg6     = 32'h8000_0018;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0]      m_mem [0:255];
    logic [7:0]      m_q [$];
    bit              m_ovf;
    longint unsigned edges;

    dmem_responder_if bus();

    dmem_responder #(.RAM_AW(12), .FIFO_AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising edges seen since reset was last released.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time %0t exceeded limit 300000", $time);
        $fatal(1);
    end

    task automatic idle_bus();
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.addr        = 32'h0;
        bus.wdata       = 32'h0;
        bus.addr_allign = 2'b00;
        bus.B           = 1'b0;
        bus.H           = 1'b0;
    endtask

    // sz: 0 byte, 1 half, 2 word. Returns at the falling edge after the store edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.mem_write   = 1'b1;
        bus.addr        = a;
        bus.wdata       = d;
        bus.addr_allign = a[1:0];
        bus.B           = (sz == 2'd0);
        bus.H           = (sz == 2'd1);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        bus.mem_read = 1'b1;
        bus.addr     = a;
        #1;
        d            = bus.rdata;
        bus.mem_read = 1'b0;
        bus.addr     = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        bus.tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        idle_bus();
        bus.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.timer_irq); end
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        n_checks++; if (bus.acc_err !== 1'b0) begin n_fail++; $display("FAIL reset_acc_err: got %b expected 0", bus.acc_err); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_idle: got %h expected 0", bus.rdata); end
        load(c_cmp_lo, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp_lo: got %h expected ffffffff", d); end
        load(c_cmp_hi, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", d); end
        load(c_status, d);
        n_checks++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status: got %h expected 00000002", d); end
        load(c_mtime_lo, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mtime: got %h expected 0", d); end
        rst = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ram_lanes();
        logic [31:0] d;
        store(32'h40, 32'h1122_3344, 2'd2);
        load(32'h40, d);
        n_checks++; if (d !== 32'h1122_3344) begin n_fail++; $display("FAIL lanes_word: got %h expected 11223344", d); end
        store(32'h41, 32'h5555_55AA, 2'd0);
        store(32'h42, 32'h1234_BEEF, 2'd1);
        load(32'h40, d);
        n_checks++; if (d !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL lanes_merge: got %h expected beefaa44", d); end
        // Simultaneous read and write: read sees the old word, store lands on the edge.
        bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.addr = 32'h40;
        bus.wdata = 32'hDEAD_BEEF; bus.addr_allign = 2'b00; bus.B = 1'b0; bus.H = 1'b0;
        #1;
        n_checks++; if (bus.rdata !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL no_bypass: got %h expected beefaa44", bus.rdata); end
        @(negedge clk);
        idle_bus();
        load(32'h40, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_conflict_store: got %h expected deadbeef", d); end
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        store(32'h43, 32'h0000_1234, 2'd1);
        #1;
        n_checks++; if (bus.acc_err !== 1'b1) begin n_fail++; $display("FAIL misal_err_pulse: got %b expected 1", bus.acc_err); end
        load(32'h40, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL misal_ram_kept: got %h expected deadbeef", d); end
        @(negedge clk); #1;
        n_checks++; if (bus.acc_err !== 1'b0) begin n_fail++; $display("FAIL misal_err_single: got %b expected 0", bus.acc_err); end
        store(32'h42, 32'h0BAD_0BAD, 2'd2);
        #1;
        n_checks++; if (bus.acc_err !== 1'b1) begin n_fail++; $display("FAIL misal_word_err: got %b expected 1", bus.acc_err); end
        load(32'h40, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL misal_word_kept: got %h expected deadbeef", d); end
    endtask

    task automatic test_random_ram();
        logic [31:0] d, exp;
        logic [31:0] wd;
        int          off, w;
        logic [1:0]  sz;
        bit          ok;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            store(32'h100 + 32'(4*i), wd, 2'd2);
            for (int b = 0; b < 4; b++) m_mem[4*i+b] = wd[8*b +: 8];
        end
        for (int i = 0; i < 80; i++) begin
            off = $urandom_range(0, 255);
            sz  = 2'($urandom_range(0, 2));
            wd  = $urandom;
            ok  = (sz == 2'd0) || (sz == 2'd1 && off % 2 == 0) || (sz == 2'd2 && off % 4 == 0);
            store(32'h100 + 32'(off), wd, sz);
            if (ok) for (int b = 0; b < (1 << sz); b++) m_mem[off+b] = wd[8*b +: 8];
            #1;
            n_checks++; if (bus.acc_err !== !ok) begin n_fail++; $display("FAIL rand_acc_err: off %0d size %0d got %b expected %b", off, sz, bus.acc_err, !ok); end
            w   = $urandom_range(0, 63);
            exp = {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
            load(32'h100 + 32'(4*w), d);
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rand_ram_word%0d: got %h expected %h", w, d, exp); end
        end
        w   = 5;
        exp = {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
        load(32'h100 + 32'(4*w) + 32'h0000_4000, d);
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL ram_alias: got %h expected %h", d, exp); end
    endtask

    task automatic test_timer();
        logic [31:0] d, a, b;
        bit          found;
        do_reset();
        store(c_cmp_hi, 32'h0, 2'd2);
        store(c_cmp_lo, 32'd100, 2'd2);
        store(c_cmp_lo, 32'h0000_0005, 2'd0);
        #1;
        n_checks++; if (bus.acc_err !== 1'b1) begin n_fail++; $display("FAIL cmp_byte_err: got %b expected 1", bus.acc_err); end
        load(c_cmp_lo, d);
        n_checks++; if (d !== 32'd100) begin n_fail++; $display("FAIL cmp_byte_ignored: got %h expected 00000064", d); end
        load(c_mtime_lo, d);
        n_checks++; if (d !== edges[31:0]) begin n_fail++; $display("FAIL mtime_value: got %0d expected %0d", d, edges[31:0]); end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            load(c_mtime_lo, d);
            if (d == 32'd100) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL mtime_reach_100: got %0d expected 100 within 200 cycles", d); end
        n_checks++; if (bus.timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_at_equal: got %b expected 0", bus.timer_irq); end
        @(negedge clk); #1;
        n_checks++; if (bus.timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", bus.timer_irq); end
        store(c_cmp_hi, 32'h1, 2'd2);
        #1;
        n_checks++; if (bus.timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_after_write: got %b expected 1", bus.timer_irq); end
        @(negedge clk); #1;
        n_checks++; if (bus.timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", bus.timer_irq); end
        load(c_mtime_lo, a);
        @(negedge clk);
        load(c_mtime_lo, b);
        n_checks++; if (b - a !== 32'd1) begin n_fail++; $display("FAIL mtime_step: got %0d expected 1", b - a); end
    endtask

    task automatic test_fifo();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            store(c_tx, 32'h0000_0041 + 32'(i), 2'd0);
            if (m_q.size() == 4) m_ovf = 1'b1;
            else m_q.push_back(8'h41 + 8'(i));
        end
        load(c_status, d);
        n_checks++; if (d !== 32'h0000_0405) begin n_fail++; $display("FAIL fifo_full_status: got %h expected 00000405", d); end
        load(c_tx, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL tx_reads_zero: got %h expected 0", d); end
        load(c_reg6, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reg6_reads_zero: got %h expected 0", d); end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== m_q[0]) begin n_fail++; $display("FAIL drain%0d: got v=%b %h expected v=1 %h", i, bus.tx_valid, bus.tx_data, m_q[0]); end
            @(negedge clk); #1;
            void'(m_q.pop_front());
        end
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b expected 0", bus.tx_valid); end
        load(c_status, d);
        n_checks++; if (d !== 32'h0000_0006) begin n_fail++; $display("FAIL drain_status: got %h expected 00000006", d); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic [7:0]  exp [$];
        do_reset();
        for (int i = 0; i < 4; i++) store(c_tx, 32'h60 + 32'(i), 2'd0);
        bus.tx_ready = 1'b1;
        store(c_tx, 32'h0000_0055, 2'd2);
        bus.tx_ready = 1'b0;
        load(c_status, d);
        n_checks++; if (d !== 32'h0000_0304) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected 00000304", d); end
        exp = '{8'h61, 8'h62, 8'h63};
        bus.tx_ready = 1'b1;
        foreach (exp[i]) begin
            n_checks++; if (bus.tx_data !== exp[i]) begin n_fail++; $display("FAIL full_pushpop_order%0d: got %h expected %h", i, bus.tx_data, exp[i]); end
            @(negedge clk); #1;
        end
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_empty: got %b expected 0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_random_fifo();
        logic [31:0] d, exp_st, wd;
        logic [1:0]  sz;
        bit          push, rdy, was_full, popped;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            push = ($urandom_range(0, 2) != 0);
            rdy  = ($urandom_range(0, 1) != 0);
            wd   = $urandom;
            sz   = 2'($urandom_range(0, 2));
            bus.tx_ready = rdy;
            #1;
            n_checks++;
            if (bus.tx_valid !== (m_q.size() != 0) || bus.tx_data !== (m_q.size() != 0 ? m_q[0] : 8'h00)) begin
                n_fail++;
                $display("FAIL rand_fifo_head%0d: got v=%b %h expected v=%b %h", i, bus.tx_valid, bus.tx_data, m_q.size() != 0, m_q.size() != 0 ? m_q[0] : 8'h00);
            end
            exp_st = (32'(m_q.size()) << 8) | (m_ovf ? 32'h4 : 32'h0)
                   | (m_q.size() == 0 ? 32'h2 : 32'h0) | (m_q.size() == 4 ? 32'h1 : 32'h0);
            load(c_status, d);
            n_checks++; if (d !== exp_st) begin n_fail++; $display("FAIL rand_fifo_status%0d: got %h expected %h", i, d, exp_st); end
            was_full = (m_q.size() == 4);
            popped   = (m_q.size() != 0) && rdy;
            if (push) store(c_tx, wd, sz);
            else @(negedge clk);
            if (push && was_full) m_ovf = 1'b1;
            if (popped) void'(m_q.pop_front());
            if (push && !was_full) m_q.push_back(wd[7:0]);
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        store(32'h200, 32'hCAFE_F00D, 2'd2);
        store(c_cmp_hi, 32'h0, 2'd2);
        store(c_cmp_lo, 32'd10, 2'd2);
        store(c_tx, 32'h71, 2'd0);
        store(c_tx, 32'h72, 2'd0);
        for (int i = 0; i < 600 && edges < 500; i++) @(negedge clk);
        #1;
        n_checks++; if (bus.tx_valid !== 1'b1 || bus.timer_irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_state: got v=%b irq=%b expected v=1 irq=1", bus.tx_valid, bus.timer_irq); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_tx_valid: got %b expected 0", bus.tx_valid); end
        n_checks++; if (bus.timer_irq !== 1'b0) begin n_fail++; $display("FAIL async_irq: got %b expected 0", bus.timer_irq); end
        load(c_mtime_lo, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL async_mtime: got %h expected 0", d); end
        load(c_status, d);
        n_checks++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL async_status: got %h expected 00000002", d); end
        // A store presented across an edge while reset is held must be lost.
        bus.mem_write = 1'b1; bus.addr = 32'h200; bus.wdata = 32'h1234_5678;
        bus.addr_allign = 2'b00; bus.B = 1'b0; bus.H = 1'b0;
        @(negedge clk);
        idle_bus();
        rst = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        load(32'h200, d);
        n_checks++; if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_survives_reset: got %h expected cafef00d", d); end
    endtask

    initial begin
        rst = 1'b1;
        idle_bus();
        bus.tx_ready = 1'b0;
        test_reset();
        test_ram_lanes();
        test_misaligned();
        test_random_ram();
        test_timer();
        test_fifo();
        test_full_push_pop();
        test_random_fifo();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
